// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous word-wide memory port between instruction fetch and
// the data stage: grant, byte-lane steering, load extension and alignment checks.
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              f_valid,
    output logic              f_ready,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_err,

    input  logic              d_valid,
    output logic              d_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_write,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [31:0]       d_wdata,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_write,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_data_in,
    input  logic [31:0]       mem_data_out
);

    // state  | meaning
    // IDLE   | arbitrate; ready only to the winner; latch request on accept
    // ACCESS | memory port driven with the latched request (one cycle)
    // RESP   | owner's response pulse; read data taken from the memory this cycle

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t            state_q, state_d;
    logic [3:0]        streak_q;

    logic              owner_q;       // 1 = data stage owns the transaction
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [31:0]       wdata_q;
    logic              err_q;

    logic              grant_d, grant_f;
    logic              f_req_err, d_req_err;
    logic [1:0]        off_q;
    logic [3:0]        lane_strb;
    logic [31:0]       lane_data;
    logic [31:0]       shifted;
    logic [31:0]       load_ext;
    logic [31:0]       resp_data;
    logic              sign_b, sign_h;

    // Data wins unless fetch has waited through a full streak of data grants.
    assign grant_d = d_valid && !(f_valid && (streak_q == STREAK_MAX));
    assign grant_f = f_valid && !grant_d;

    assign f_req_err = |f_addr[1:0];
    assign d_req_err = (d_size == 2'b11)
                    || ((d_size == 2'b10) && (|d_addr[1:0]))
                    || ((d_size == 2'b01) && d_addr[0]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        f_ready = 1'b0;
        d_ready = 1'b0;
        case (state_q)
            IDLE: begin
                f_ready = reset_n && grant_f;
                d_ready = reset_n && grant_d;
                if (grant_d) begin
                    state_d = d_req_err ? RESP : ACCESS;
                end else if (grant_f) begin
                    state_d = f_req_err ? RESP : ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_q    <= 1'b0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            streak_q   <= 4'd0;
        end else if (state_q == IDLE) begin
            if (grant_d) begin
                owner_q    <= 1'b1;
                addr_q     <= d_addr;
                write_q    <= d_write;
                size_q     <= d_size;
                unsigned_q <= d_unsigned;
                wdata_q    <= d_wdata;
                err_q      <= d_req_err;
                streak_q   <= f_valid ? (streak_q + 4'd1) : 4'd0;
            end else if (grant_f) begin
                owner_q    <= 1'b0;
                addr_q     <= f_addr;
                write_q    <= 1'b0;
                size_q     <= 2'b10;
                unsigned_q <= 1'b1;
                wdata_q    <= 32'd0;
                err_q      <= f_req_err;
                streak_q   <= 4'd0;
            end
        end
    end

    assign off_q = addr_q[1:0];

    // Store lane steering: data replicated across lanes, strobes select the target bytes.
    always_comb begin
        case (size_q)
            2'b00: begin
                lane_strb = 4'b0001 << off_q;
                lane_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_strb = 4'b0011 << off_q;
                lane_data = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_strb = 4'b1111;
                lane_data = wdata_q;
            end
        endcase
    end

    always_comb begin
        mem_address    = '0;
        mem_read_write = 1'b0;
        mem_wstrb      = 4'b0000;
        mem_data_in    = 32'd0;
        if (state_q == ACCESS) begin
            mem_address = {addr_q[ADDR_W-1:2], 2'b00};
            if (write_q) begin
                mem_read_write = 1'b1;
                mem_wstrb      = lane_strb;
                mem_data_in    = lane_data;
            end
        end
    end

    assign shifted = mem_data_out >> {off_q, 3'b000};
    assign sign_b  = !unsigned_q && shifted[7];
    assign sign_h  = !unsigned_q && shifted[15];

    always_comb begin
        case (size_q)
            2'b00:   load_ext = {{24{sign_b}}, shifted[7:0]};
            2'b01:   load_ext = {{16{sign_h}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Stores and rejected requests return zero data.
    always_comb begin
        resp_data = 32'd0;
        if (!err_q && !write_q) begin
            resp_data = owner_q ? load_ext : mem_data_out;
        end
    end

    always_comb begin
        f_rvalid = 1'b0;
        f_err    = 1'b0;
        f_rdata  = 32'd0;
        d_rvalid = 1'b0;
        d_err    = 1'b0;
        d_rdata  = 32'd0;
        if (state_q == RESP) begin
            if (owner_q) begin
                d_rvalid = 1'b1;
                d_err    = err_q;
                d_rdata  = resp_data;
            end else begin
                f_rvalid = 1'b1;
                f_err    = err_q;
                f_rdata  = resp_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: byte-level reference memory model checked every
// cycle, plus literal expectations for the documented scenarios.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int MAX_STREAK = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        f_valid, f_ready, f_rvalid, f_err;
    logic [31:0] f_addr, f_rdata;
    logic        d_valid, d_ready, d_write, d_unsigned, d_rvalid, d_err;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_read_write;
    logic [3:0]  mem_wstrb;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(32), .MAX_DATA_STREAK(MAX_STREAK)) dut (
        .clock(clock), .reset_n(reset_n),
        .f_valid(f_valid), .f_ready(f_ready), .f_addr(f_addr),
        .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_write(d_write),
        .d_size(d_size), .d_unsigned(d_unsigned), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_address(mem_address), .mem_read_write(mem_read_write),
        .mem_wstrb(mem_wstrb), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    function automatic logic [31:0] init_val(input int widx);
        case (widx)
            4:       return 32'h00500093;
            5:       return 32'h12345678;
            8:       return 32'h80FF7F01;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Storage block the arbiter drives: one-cycle synchronous read, byte-strobed write.
    logic [31:0] memw [0:63];
    initial begin
        for (int i = 0; i < 64; i++) memw[i] = init_val(i);
        mem_data_out = 32'h0;
        forever begin
            @(posedge clock);
            for (int k = 0; k < 4; k++)
                if (mem_read_write && mem_wstrb[k])
                    memw[mem_address[7:2]][8*k +: 8] <= mem_data_in[8*k +: 8];
            mem_data_out <= memw[mem_address[7:2]];
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_bytes [0:255];
    int          next_ok, acc_at, resp_at, streak_m;
    logic        m_owner, m_write, m_uns, m_err;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        log_en;
    bit          grant_q[$];
    int          grant_cyc[$];

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz,
                                               input logic uns);
        int n;
        logic [63:0] v;
        n = 1 << sz;
        v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_bytes[(a + i) & 255]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    initial begin
        logic        gd, gf, e_rw, fr, dr;
        logic [3:0]  e_strb;
        logic [31:0] e_addr, e_din, e_rdata, w;
        int          n, off;
        for (int i = 0; i < 64; i++) begin
            w = init_val(i);
            for (int k = 0; k < 4; k++) ref_bytes[4*i + k] = w[8*k +: 8];
        end
        next_ok = 0; acc_at = -1; resp_at = -1; streak_m = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                check("reset_outputs",
                      {f_ready, d_ready, f_rvalid, d_rvalid, f_err, d_err, mem_read_write,
                       mem_wstrb, |f_rdata, |d_rdata, |mem_address, |mem_data_in}, 64'd0);
                next_ok = 0; acc_at = -1; resp_at = -1; streak_m = 0;
            end else begin
                e_addr = 0; e_rw = 0; e_strb = 0; e_din = 0;
                if (cyc == acc_at) begin
                    e_addr = m_addr & ~32'd3;
                    if (m_write) begin
                        e_rw = 1'b1;
                        n    = 1 << m_size;
                        off  = int'(m_addr[1:0]);
                        for (int k = 0; k < 4; k++)
                            if (k >= off && k < off + n) begin
                                e_strb[k] = 1'b1;
                                ref_bytes[(e_addr + k) & 255] = m_wdata[8*(k-off) +: 8];
                            end
                        e_din = (m_size == 0) ? {4{m_wdata[7:0]}} :
                                (m_size == 1) ? {2{m_wdata[15:0]}} : m_wdata;
                    end
                end
                check("mem_addr_rw_strb", {mem_address, mem_read_write, mem_wstrb},
                      {e_addr, e_rw, e_strb});
                check("mem_data_in", mem_data_in, e_din);

                e_rdata = 0;
                fr = (cyc == resp_at) && !m_owner;
                dr = (cyc == resp_at) && m_owner;
                if ((fr || dr) && !m_err && !m_write)
                    e_rdata = m_owner ? model_read(m_addr, m_size, m_uns)
                                      : model_read(m_addr, 2'd2, 1'b1);
                check("f_resp", {f_rvalid, f_err, f_rdata}, {fr, fr && m_err, fr ? e_rdata : 32'd0});
                check("d_resp", {d_rvalid, d_err, d_rdata}, {dr, dr && m_err, dr ? e_rdata : 32'd0});

                gd = 0; gf = 0;
                if (cyc >= next_ok) begin
                    gd = d_valid && !(f_valid && streak_m == MAX_STREAK);
                    gf = f_valid && !gd;
                end
                check("ready", {f_ready, d_ready}, {gf, gd});
                if (log_en && ((f_valid && f_ready) || (d_valid && d_ready))) begin
                    grant_q.push_back(d_valid && d_ready);
                    grant_cyc.push_back(cyc);
                end
                if (gd) begin
                    m_owner = 1; m_addr = d_addr; m_write = d_write; m_size = d_size;
                    m_uns = d_unsigned; m_wdata = d_wdata;
                    m_err = (d_size == 3) || (d_size == 2 && d_addr[1:0] != 0) ||
                            (d_size == 1 && d_addr[0]);
                    streak_m = f_valid ? streak_m + 1 : 0;
                end else if (gf) begin
                    m_owner = 0; m_addr = f_addr; m_write = 0; m_size = 2; m_uns = 1;
                    m_wdata = 0; m_err = (f_addr[1:0] != 0);
                    streak_m = 0;
                end
                if (gd || gf) begin
                    acc_at  = m_err ? -1 : cyc + 1;
                    resp_at = m_err ? cyc + 1 : cyc + 2;
                    next_ok = m_err ? cyc + 2 : cyc + 3;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] last_addr, last_din;
    logic        last_rw;
    logic [3:0]  last_strb;

    task automatic req(input string name, input bit is_d, input logic [31:0] a, input bit wr,
                       input logic [1:0] sz, input bit uns, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input bit exp_err);
        bit got;
        int lat;
        @(posedge clock); #1;
        if (is_d) begin
            d_valid = 1; d_addr = a; d_write = wr; d_size = sz; d_unsigned = uns; d_wdata = wd;
        end else begin
            f_valid = 1; f_addr = a;
        end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (is_d ? d_ready : f_ready) got = 1;
        end
        check({name, "_accept"}, got, 1);
        @(posedge clock); #1;
        d_valid = 0; f_valid = 0;
        got = 0; lat = 1;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clock);
            if (i == 0) begin
                last_addr = mem_address; last_rw = mem_read_write;
                last_strb = mem_wstrb;   last_din = mem_data_in;
            end
            if (is_d ? d_rvalid : f_rvalid) got = 1;
            else lat++;
        end
        check({name, "_latency"}, got ? lat : 99, exp_err ? 1 : 2);
        if (is_d) check({name, "_data"}, {d_err, d_rdata}, {exp_err, exp_rd});
        else      check({name, "_data"}, {f_err, f_rdata}, {exp_err, exp_rd});
    endtask

    task automatic both_held(input string name, input int ngrants, input string exp_order);
        string s;
        int    bad;
        grant_q.delete(); grant_cyc.delete();
        @(posedge clock); #1;
        f_valid = 1; f_addr = 32'h10;
        d_valid = 1; d_addr = 32'h20; d_write = 0; d_size = 2; d_unsigned = 0;
        log_en = 1;
        for (int i = 0; i < 80 && grant_q.size() < ngrants; i++) @(negedge clock);
        @(posedge clock); #1;
        f_valid = 0; d_valid = 0; log_en = 0;
        s = "";
        foreach (grant_q[i]) s = {s, grant_q[i] ? "D" : "F"};
        vectors++;
        if (s != exp_order) begin
            miscompares++;
            $display("FAIL %s_order: got %s expected %s", name, s, exp_order);
        end
        bad = 0;
        for (int i = 1; i < grant_cyc.size(); i++)
            if (grant_cyc[i] - grant_cyc[i-1] != 3) bad++;
        check({name, "_spacing_errors"}, bad, 0);
        repeat (3) @(posedge clock);
    endtask

    initial begin
        logic [3:0] strb_pre, strb_post;
        bit         seen, got;
        reset_n = 0; log_en = 0;
        f_valid = 1; f_addr = 32'h10;
        d_valid = 0; d_addr = 0; d_write = 0; d_size = 0; d_unsigned = 0; d_wdata = 0;
        @(negedge clock);
        check("ready_held_low_in_reset", f_ready, 0);
        f_valid = 0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1;

        req("fetch_0x10", 0, 32'h10, 0, 2, 0, 0, 32'h00500093, 0);
        check("fetch_bus", {last_addr, last_rw, last_strb}, {32'h10, 1'b0, 4'h0});
        req("lb_0x23", 1, 32'h23, 0, 0, 0, 0, 32'hFFFFFF80, 0);
        req("lbu_0x23", 1, 32'h23, 0, 0, 1, 0, 32'h00000080, 0);
        req("lh_0x22", 1, 32'h22, 0, 1, 0, 0, 32'hFFFF80FF, 0);
        req("lw_0x20", 1, 32'h20, 0, 2, 0, 0, 32'h80FF7F01, 0);
        req("lb_0x21", 1, 32'h21, 0, 0, 0, 0, 32'h0000007F, 0);
        req("sh_0x26", 1, 32'h26, 1, 1, 0, 32'h00001234, 0, 0);
        check("sh_bus_addr", last_addr, 32'h24);
        check("sh_bus_ctrl", {last_rw, last_strb}, {1'b1, 4'b1100});
        check("sh_bus_data", last_din, 32'h12341234);
        req("sb_0x25", 1, 32'h25, 1, 0, 0, 32'hFFFFFFAB, 0, 0);
        check("sb_bus", {last_strb, last_din}, {4'b0010, 32'hABABABAB});
        req("lw_0x24", 1, 32'h24, 0, 2, 0, 0, 32'h1234AB00, 0);
        req("lhu_0x26", 1, 32'h26, 0, 1, 1, 0, 32'h00001234, 0);
        req("lw_misaligned", 1, 32'h02, 0, 2, 0, 0, 0, 1);
        check("err_no_bus", {last_addr, last_strb}, 36'd0);
        req("size_illegal", 1, 32'h20, 0, 3, 0, 0, 0, 1);
        req("lh_misaligned", 1, 32'h21, 0, 1, 0, 0, 0, 1);
        req("sw_misaligned", 1, 32'h26, 1, 2, 0, 32'hFFFFFFFF, 0, 1);
        req("lw_0x24_again", 1, 32'h24, 0, 2, 0, 0, 32'h1234AB00, 0);
        req("fetch_misaligned", 0, 32'h12, 0, 2, 0, 0, 0, 1);
        req("fetch_0x14", 0, 32'h14, 0, 2, 0, 0, 32'h12345678, 0);

        both_held("streak", 10, "DDDDFDDDDF");

        // Word store interrupted by reset while the memory port is being driven.
        @(posedge clock); #1;
        f_valid = 1; f_addr = 32'h10;
        d_valid = 1; d_addr = 32'h30; d_write = 1; d_size = 2; d_unsigned = 0;
        d_wdata = 32'hDEADBEEF;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (d_ready) got = 1;
        end
        check("rst_store_accept", got, 1);
        @(posedge clock); #1;
        strb_pre = mem_wstrb;
        reset_n = 0; d_valid = 0; f_valid = 0; d_write = 0;
        #1 strb_post = mem_wstrb;
        check("strb_before_reset", strb_pre, 4'hF);
        check("strb_during_reset", strb_post, 4'h0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1;
        seen = 0;
        repeat (4) begin
            @(negedge clock);
            if (d_rvalid) seen = 1;
        end
        check("no_resp_after_reset", seen, 0);
        both_held("post_reset", 5, "DDDDF");
        req("lw_0x30_unwritten", 1, 32'h30, 0, 2, 0, 0, 32'h0, 0);

        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-addressed main memory between the fetch stage (word reads) and the memory stage (loads/stores of byte, half or word).
- Grants one requester per transaction, drives the memory's one-cycle synchronous word port, and returns responses.
- Performs byte-lane steering, write strobes, sign/zero extension and alignment checking.
- Sits between the pipeline stages and the memory array; the memory itself stays a dumb storage block.

Parameters:
- ADDR_W, 32, address width of all ports.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits before fetch is forced through (range 1..15).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- f_valid  in  1  fetch request valid
- f_ready  out  1  fetch request accepted this cycle when f_valid & f_ready
- f_addr  in  32  fetch byte address
- f_rvalid  out  1  one-cycle fetch response pulse
- f_rdata  out  32  fetched instruction word
- f_err  out  1  qualifies f_rvalid: misaligned fetch
- d_valid  in  1  data request valid
- d_ready  out  1  data request accepted when d_valid & d_ready
- d_addr  in  32  data byte address
- d_write  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_unsigned  in  1  load zero-extends when 1
- d_wdata  in  32  store data, right-justified
- d_rvalid  out  1  one-cycle data response pulse (loads and stores)
- d_rdata  out  32  extended load data; 0 for stores and errors
- d_err  out  1  qualifies d_rvalid: misaligned or illegal size
- mem_address  out  32  word-aligned address to memory
- mem_read_write  out  1  1 = write
- mem_wstrb  out  4  byte-lane write enables, bit k = bits 8k+7:8k
- mem_data_in  out  32  lane-steered write data
- mem_data_out  in  32  memory read word, valid the cycle after the address is presented

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: arbitration is combinational; ready is asserted only to the winner; on valid & ready, latch the request and the owner, then go to ACCESS (or to RESP directly if the request has an error).
  - ACCESS (1 cycle): drive mem_address = addr & ~3. For a write, also drive mem_read_write = 1, mem_wstrb and mem_data_in. Go to RESP.
  - RESP (1 cycle): owner's rvalid = 1 and rdata is extracted combinationally from mem_data_out. Go to IDLE.
- Latency and throughput:
  - Accept at cycle T, memory driven at T+1, response at T+2.
  - Next accept no earlier than T+3.
  - Ready is low outside IDLE.
- Idle memory outputs: outside ACCESS, mem_address = 0, mem_read_write = 0, mem_wstrb = 0, mem_data_in = 0.
- Arbitration:
  - Data has priority over fetch.
  - streak counter (4 bits) increments on each data grant made while f_valid = 1.
  - When streak == MAX_DATA_STREAK and f_valid = 1, fetch wins.
  - streak clears on any fetch grant, or when data is granted with f_valid = 0.
  - With a single requester valid, that requester wins.
- Alignment and errors:
  - Word requires addr[1:0] == 0; half requires addr[0] == 0.
  - Fetch is always a word access.
  - d_size == 11 is an error.
  - An error request is accepted normally, skips ACCESS, makes no memory access, returns rvalid with err = 1 and rdata = 0 at T+1.
- Stores, with off = addr[1:0]:
  - byte: wstrb = 0001 << off, mem_data_in = {4{wdata[7:0]}}.
  - half: wstrb = 0011 << off, mem_data_in = {2{wdata[15:0]}}.
  - word: wstrb = 1111, mem_data_in = wdata.
- Loads: shift mem_data_out right by 8*off, take the low 8/16/32 bits, then sign-extend, or zero-extend if d_unsigned. Fetch returns mem_data_out unmodified.
- Response pulse: rvalid/err/rdata are all zero except in the RESP cycle of their owner.
- Requester obligations: requesters must hold valid and payload stable until accepted; a request deasserted before accept is simply not serviced.
- Reset:
  - reset_n low immediately forces IDLE, streak = 0 and all outputs to 0.
  - A transaction in flight at reset is abandoned with no response; a write in ACCESS is aborted (strobes drop with reset).

Test Plan:
- Fetch only, f_addr = 0x10, mem word 0x00500093 -> f_ready at T; mem_address = 0x10 at T+1; f_rvalid = 1, f_rdata = 0x00500093 at T+2.
- Load byte signed at 0x23, mem word at 0x20 = 0x80FF7F01 -> d_rdata = 0xFFFFFF80; same with d_unsigned = 1 -> 0x00000080; load half at 0x22 signed -> 0xFFFF80FF.
- Store half 0x1234 to 0x26 -> at T+1: mem_address = 0x24, wstrb = 1100, mem_data_in = 0x12341234, read_write = 1; d_rvalid at T+2 with d_rdata = 0.
- Misaligned word load at 0x02 -> d_rvalid and d_err = 1 at T+1, no cycle with nonzero mem_wstrb or mem_address; d_size = 11 behaves the same.
- f_valid and d_valid held high continuously, MAX_DATA_STREAK = 4 -> grant order D,D,D,D,F,D,D,D,D,F; each grant spaced 3 cycles apart.
- Assert reset_n low during ACCESS of a word store -> wstrb drops to 0 in the same cycle, no d_rvalid; after release, d_ready is asserted from IDLE and streak = 0.
